// File: rtl/crc_serial_engine.sv
// -----------------------------------------------------------------------------
// crc_serial_engine
//
// Bit-serial CRC engine. In generate mode it runs the message through the CRC
// register and then shifts the remainder out MSB first. In check mode it runs
// the message followed by the received CRC bits through the register; a zero
// remainder means the frame is intact.
//
// Build option:
//   CRC_CTRL_POLY_EN  when defined, adds input ctrl_poly; the polynomial used
//                     for a frame is taken from it at start instead of POLY.
//
// Parameters:
//   CRC_W   CRC width in bits (2..32)
//   POLY    generator polynomial, implicit x^CRC_W term omitted
//   INIT    register preset loaded on start
//   LEN_W   width of the message-length field
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          begin a frame (only honoured in IDLE)
//   mode           0 = generate, 1 = check (sampled with start)
//   msg_len        number of message bits (sampled with start)
//   abort          cancel the current frame, back to IDLE without done
//   data_in        serial data, MSB first
//   data_valid     data_in is valid
//   ctrl_poly      per-frame polynomial (CRC_CTRL_POLY_EN builds only)
//   data_ready     engine accepts a bit this cycle (SHIFT and CHECK)
//   crc_out_bit    appended CRC bit, MSB first
//   crc_out_valid  crc_out_bit is valid
//   crc_seq        final remainder of the last completed frame
//   busy           high in every state except IDLE
//   done           one-cycle end-of-frame pulse
//   crc_error      check-mode result (nonzero remainder), held until next start
//   dbg_state      current FSM state encoding, for observation only
//
// Handshake: a serial bit is transferred on a rising edge where both
// data_valid and data_ready are high; data_valid may be dropped for any number
// of cycles and the engine simply waits. crc_out_bit is presented whenever
// crc_out_valid is high and has no back-pressure.
// -----------------------------------------------------------------------------
module crc_serial_engine #(
    parameter int               CRC_W = 4,
    parameter logic [CRC_W-1:0] POLY  = 4'b0011,
    parameter logic [CRC_W-1:0] INIT  = '0,
    parameter int               LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [LEN_W-1:0] msg_len,
    input  logic             abort,
    input  logic             data_in,
    input  logic             data_valid,
`ifdef CRC_CTRL_POLY_EN
    input  logic [CRC_W-1:0] ctrl_poly,
`endif
    output logic             data_ready,
    output logic             crc_out_bit,
    output logic             crc_out_valid,
    output logic [CRC_W-1:0] crc_seq,
    output logic             busy,
    output logic             done,
    output logic             crc_error,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_APPEND = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CRC_W-1:0] r_crc;
    logic [CRC_W-1:0] r_rem;      // remainder captured at SHIFT exit (generate)
    logic [CRC_W-1:0] r_seq;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;      // message bits accepted so far
    logic [5:0]       r_tail;     // CRC bits emitted (APPEND) or accepted (CHECK)
    logic             r_mode;
    logic             r_ready;
    logic             r_out_bit;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic [CRC_W-1:0] w_poly;
    logic             w_accept;
    logic             w_fb;
    logic [CRC_W-1:0] w_crc_next;
    logic             w_last_msg;
    logic             w_last_tail;

`ifdef CRC_CTRL_POLY_EN
    logic [CRC_W-1:0] r_poly;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_poly <= POLY;
        end else if (r_state == S_IDLE && start && !abort) begin
            r_poly <= ctrl_poly;
        end
    end

    assign w_poly = r_poly;
`else
    assign w_poly = POLY;
`endif

    assign w_accept    = data_valid && r_ready;
    assign w_fb        = r_crc[CRC_W-1] ^ data_in;
    assign w_crc_next  = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? w_poly : '0);
    assign w_last_msg  = (r_cnt + LEN_W'(1)) == r_len;
    assign w_last_tail = r_tail == 6'(CRC_W - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_crc       <= '0;
            r_rem       <= '0;
            r_seq       <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_tail      <= '0;
            r_mode      <= 1'b0;
            r_ready     <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else if (abort && r_state != S_IDLE) begin
            // Drop the frame; crc_seq and crc_error keep the last result.
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start && !abort) begin
                        r_crc  <= INIT;
                        r_mode <= mode;
                        r_len  <= msg_len;
                        r_cnt  <= '0;
                        r_tail <= '0;
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (msg_len != '0) begin
                            r_state <= S_SHIFT;
                            r_ready <= 1'b1;
                        end else if (mode) begin
                            r_state <= S_CHECK;
                            r_ready <= 1'b1;
                        end else begin
                            // Empty message: the remainder is the preset itself.
                            r_state     <= S_APPEND;
                            r_rem       <= INIT;
                            r_out_valid <= 1'b1;
                            r_out_bit   <= INIT[CRC_W-1];
                        end
                    end
                end

                S_SHIFT: begin
                    if (w_accept) begin
                        r_crc <= w_crc_next;
                        r_cnt <= r_cnt + LEN_W'(1);
                        if (w_last_msg) begin
                            r_tail <= '0;
                            if (r_mode) begin
                                r_state <= S_CHECK;
                            end else begin
                                r_state     <= S_APPEND;
                                r_ready     <= 1'b0;
                                r_rem       <= w_crc_next;
                                r_out_valid <= 1'b1;
                                r_out_bit   <= w_crc_next[CRC_W-1];
                            end
                        end
                    end
                end

                S_APPEND: begin
                    // The output register always shows the MSB of r_crc, so the
                    // next bit out is the one about to shift into the MSB.
                    r_crc  <= {r_crc[CRC_W-2:0], 1'b0};
                    r_tail <= r_tail + 6'd1;
                    if (w_last_tail) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b0;
                        r_out_bit   <= 1'b0;
                        r_done      <= 1'b1;
                        r_seq       <= r_rem;
                        r_err       <= 1'b0;
                    end else begin
                        r_out_bit <= r_crc[CRC_W-2];
                    end
                end

                S_CHECK: begin
                    if (w_accept) begin
                        r_crc  <= w_crc_next;
                        r_tail <= r_tail + 6'd1;
                        if (w_last_tail) begin
                            r_state <= S_DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_seq   <= w_crc_next;
                            r_err   <= |w_crc_next;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_ready     <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_bit   <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready    = r_ready;
    assign crc_out_bit   = r_out_bit;
    assign crc_out_valid = r_out_valid;
    assign crc_seq       = r_seq;
    assign busy          = r_busy;
    assign done          = r_done;
    assign crc_error     = r_err;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_crc_serial_engine.sv
// -----------------------------------------------------------------------------
// tb_crc_serial_engine
//
// Directed bench for crc_serial_engine (CRC_W=4, POLY=x^4+x+1, INIT=0).
// The reference is polynomial long division: the register contents after
// feeding a bit sequence S from a zero preset equal S(x)*x^W mod G(x).
// -----------------------------------------------------------------------------
module tb_crc_serial_engine;

    localparam int               CRC_W = 4;
    localparam int               LEN_W = 8;
    localparam logic [CRC_W-1:0] POLY  = 4'b0011;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             mode;
    logic [LEN_W-1:0] msg_len;
    logic             abort;
    logic             data_in;
    logic             data_valid;
    logic             data_ready;
    logic             crc_out_bit;
    logic             crc_out_valid;
    logic [CRC_W-1:0] crc_seq;
    logic             busy;
    logic             done;
    logic             crc_error;
    logic [2:0]       dbg_state;
`ifdef CRC_CTRL_POLY_EN
    logic [CRC_W-1:0] ctrl_poly = 4'b0011;
`endif

    always #5 clk = ~clk;

    crc_serial_engine #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  ('0),
        .LEN_W (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mode          (mode),
        .msg_len       (msg_len),
        .abort         (abort),
        .data_in       (data_in),
        .data_valid    (data_valid),
`ifdef CRC_CTRL_POLY_EN
        .ctrl_poly     (ctrl_poly),
`endif
        .data_ready    (data_ready),
        .crc_out_bit   (crc_out_bit),
        .crc_out_valid (crc_out_valid),
        .crc_seq       (crc_seq),
        .busy          (busy),
        .done          (done),
        .crc_error     (crc_error),
        .dbg_state     (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic             bit_q[$];          // expected crc_out_bit stream
    logic [CRC_W:0]   exp_q[$];          // expected {crc_error, crc_seq} per done
    logic [CRC_W-1:0] last_seq = '0;
    logic             last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [CRC_W-1:0] model_rem(input logic [63:0] seq, input int n);
        logic [95:0]    d;
        logic [CRC_W:0] g;
        g = {1'b1, POLY};
        d = 96'(seq) << CRC_W;
        for (int i = n + CRC_W - 1; i >= CRC_W; i--) begin
            if (d[i]) d[i -: CRC_W + 1] = d[i -: CRC_W + 1] ^ g;
        end
        return d[CRC_W-1:0];
    endfunction

    task automatic push_expect(input logic m, input int len, input logic [31:0] msg,
                               input logic [CRC_W-1:0] rx_crc, input bit with_done);
        logic [CRC_W-1:0] r;
        logic [63:0]      s;
        if (!m) begin
            r = model_rem(64'(msg), len);
            for (int i = CRC_W - 1; i >= 0; i--) bit_q.push_back(r[i]);
            if (with_done) exp_q.push_back({1'b0, r});
        end else begin
            s = (64'(msg) << CRC_W) | 64'(rx_crc);
            r = model_rem(s, len + CRC_W);
            if (with_done) exp_q.push_back({(r != '0), r});
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [CRC_W:0] e;
        if (crc_out_valid === 1'b1) begin
            if (bit_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL crc_out_extra: got crc_out_valid=1 expected no output at %0t", $time);
            end else begin
                check("crc_out_bit", crc_out_bit, bit_q.pop_front());
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL done_extra: got done=1 expected none at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("crc_seq", crc_seq, e[CRC_W-1:0]);
                check("crc_error", crc_error, e[CRC_W]);
                last_seq = e[CRC_W-1:0];
                last_err = e[CRC_W];
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0; abort = 1'b0; data_valid = 1'b0; data_in = 1'b0;
        mode = 1'b0; msg_len = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},          busy,          0);
        check({tag, "_done"},          done,          0);
        check({tag, "_data_ready"},    data_ready,    0);
        check({tag, "_crc_out_valid"}, crc_out_valid, 0);
        check({tag, "_crc_out_bit"},   crc_out_bit,   0);
        check({tag, "_crc_seq"},       crc_seq,       0);
        check({tag, "_crc_error"},     crc_error,     0);
    endtask

    task automatic start_frame(input logic m, input int len);
        mode = m;
        msg_len = LEN_W'(len);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_bit(input logic b, input bit stall);
        if (stall) begin
            // Idle cycle with a stray start and a wrong data bit, both ignored.
            data_valid = 1'b0;
            data_in = ~b;
            start = 1'b1;
            check("data_ready_stall", data_ready, 1);
            tick();
            start = 1'b0;
        end
        data_valid = 1'b1;
        data_in = b;
        check("data_ready", data_ready, 1);
        tick();
        data_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t = 0;
        while (done_cnt == d0 && t < 40) begin
            tick();
            t++;
        end
        check("done_seen", done_cnt, d0 + 1);
        tick();
        check("busy_after_done", busy, 0);
    endtask

    task automatic run_frame(input logic m, input int len, input logic [31:0] msg,
                             input logic [CRC_W-1:0] rx_crc, input bit stall);
        int d0;
        d0 = done_cnt;
        push_expect(m, len, msg, rx_crc, 1'b1);
        start_frame(m, len);
        for (int i = len - 1; i >= 0; i--) send_bit(msg[i], stall);
        if (m) begin
            for (int i = CRC_W - 1; i >= 0; i--) send_bit(rx_crc[i], 1'b0);
        end
        wait_done(d0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        int t;
        do_reset();
        check_all_zero("reset");
        check("reset_state", dbg_state, 0);

        // Pin the model to hand-computed values.
        check("model_gen",       model_rem(64'b10100110, 8), 4'b1110);
        check("model_chk_pass",  model_rem(64'b101001101110, 12), 4'b0000);
        check("model_chk_fail",  model_rem(64'b101000101110, 12), 4'b0111);

        // Generate: 10100110 -> 1110 appended.
        run_frame(1'b0, 8, 32'b10100110, 4'b0000, 1'b0);
        check("gen_seq_literal", crc_seq, 4'b1110);
        check("gen_err_literal", crc_error, 0);

        // Check pass.
        run_frame(1'b1, 8, 32'b10100110, 4'b1110, 1'b0);
        check("chk_pass_seq_literal", crc_seq, 4'b0000);
        check("chk_pass_err_literal", crc_error, 0);

        // Check fail.
        run_frame(1'b1, 8, 32'b10100010, 4'b1110, 1'b0);
        check("chk_fail_err_literal", crc_error, 1);

        // Generate with a stall before every bit.
        run_frame(1'b0, 8, 32'b10100110, 4'b0000, 1'b1);
        check("stall_seq_literal", crc_seq, 4'b1110);

        // Abort wins over start in IDLE.
        mode = 1'b0; msg_len = 8'd8; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_start_busy", busy, 0);
        check("abort_start_ready", data_ready, 0);

        // Abort after four message bits.
        d0 = done_cnt;
        start_frame(1'b0, 8);
        for (int i = 7; i >= 4; i--) send_bit(1'(8'b10100110 >> i), 1'b0);
        check("busy_before_abort", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", data_ready, 0);
        tick();
        tick();
        check("abort_no_done", done_cnt, d0);
        check("abort_seq_held", crc_seq, last_seq);
        check("abort_err_held", crc_error, last_err);

        // Reset in the middle of APPEND.
        push_expect(1'b0, 8, 32'b11001010, 4'b0000, 1'b0);
        start_frame(1'b0, 8);
        for (int i = 7; i >= 0; i--) send_bit(1'(8'b11001010 >> i), 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("append_was_running", (bit_q.size() > 0 && bit_q.size() < CRC_W), 1);
        bit_q.delete();
        check("rst_no_done", done_cnt, d0);
        check_all_zero("rst_mid");

        // Empty message: straight into APPEND, emits INIT.
        d0 = done_cnt;
        push_expect(1'b0, 0, 32'b0, 4'b0000, 1'b1);
        start_frame(1'b0, 0);
        check("len0_append_now", crc_out_valid, 1);
        check("len0_no_ready", data_ready, 0);
        wait_done(d0);
        check("len0_seq_literal", crc_seq, 4'b0000);

        // One more generate with a different message after all of the above.
        run_frame(1'b0, 5, 32'b10111, 4'b0000, 1'b0);

        // Drain: nothing left unmatched.
        t = 0;
        while ((bit_q.size() != 0 || exp_q.size() != 0) && t < 20) begin
            tick();
            t++;
        end
        check("bit_q_empty", bit_q.size(), 0);
        check("exp_q_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected bench completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/crc_serial_engine.md
CRC_SERIAL_ENGINE -- requirements
Module: crc_serial_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 4: CRC width in bits, legal range 2..32.
REQ-002 SHALL have parameter POLY, default 4'b0011 (x^4+x+1): generator polynomial, implicit x^CRC_W term omitted.
REQ-003 SHALL have parameter INIT, default 0: register preset applied on start.
REQ-004 SHALL have parameter LEN_W, default 8: width of the message-length field.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: begin a frame; sampled only in IDLE.
REQ-008 SHALL have port mode, input, 1: 0 = generate, 1 = check; sampled with start.
REQ-009 SHALL have port msg_len, input, LEN_W: number of message bits; sampled with start.
REQ-010 SHALL have port abort, input, 1: cancel the current frame.
REQ-011 SHALL have port data_in, input, 1: serial data, MSB first.
REQ-012 SHALL have port data_valid, input, 1: data_in is valid.
REQ-013 SHALL have port data_ready, output, 1: engine accepts a bit this cycle.
REQ-014 SHALL have port crc_out_bit, output, 1: appended CRC bit, MSB first.
REQ-015 SHALL have port crc_out_valid, output, 1: crc_out_bit is valid.
REQ-016 SHALL have port crc_seq, output, CRC_W: final remainder of the last completed frame.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle end-of-frame pulse.
REQ-019 SHALL have port crc_error, output, 1: check-mode result, nonzero remainder.

Function
REQ-020 SHALL implement FSM states IDLE, SHIFT, APPEND, CHECK, DONE.
REQ-021 SHALL, in IDLE with start=1, load the register with INIT, latch mode and msg_len, clear the bit counter, and enter SHIFT.
REQ-022 SHALL, in IDLE with start=1 and msg_len=0, enter APPEND (mode 0) or CHECK (mode 1) directly.
REQ-023 SHALL drive data_ready=1 only in SHIFT and CHECK; a bit is accepted on data_valid&&data_ready.
REQ-024 SHALL, per accepted bit, compute fb = crc[CRC_W-1]^data_in and set crc <= {crc[CRC_W-2:0],0} ^ (fb ? poly : 0).
REQ-025 SHALL hold crc and the counter unchanged on cycles without an accepted bit; stalls are unlimited.
REQ-026 SHALL, on acceptance of bit msg_len, move from SHIFT to APPEND (mode 0) or CHECK (mode 1) on the next cycle.
REQ-027 SHALL, in APPEND, assert crc_out_valid for exactly CRC_W consecutive cycles with crc_out_bit=crc[CRC_W-1], shifting left with zero fill each cycle, then enter DONE.
REQ-028 SHALL, in CHECK, accept exactly CRC_W received CRC bits using REQ-024, then enter DONE.
REQ-029 SHALL, in DONE, assert done for one cycle, update crc_seq, and return to IDLE.
REQ-030 SHALL update crc_seq to the remainder at SHIFT exit in mode 0, and to the post-CHECK remainder in mode 1.
REQ-031 SHALL set crc_error in DONE to (remainder!=0) in mode 1, or to 0 in mode 0, and hold it until the next start.
REQ-032 SHALL, on abort in any non-IDLE state, enter IDLE next cycle with no done pulse and no crc_seq or crc_error update.
REQ-033 SHALL give abort priority over start when both are asserted in IDLE, leaving the engine in IDLE.
REQ-034 SHALL ignore start outside IDLE.

Reset
REQ-035 SHALL, on rst=1 at a clock edge, enter IDLE and clear crc, the counter, crc_seq, crc_error, done, crc_out_valid, crc_out_bit, data_ready and busy to 0.
REQ-036 SHALL, on rst asserted mid-frame, discard the frame with no done pulse.

Configuration
REQ-037 SHALL, with macro CRC_CTRL_POLY_EN defined, add input ctrl_poly[CRC_W-1:0] sampled at start and used as poly for that frame.
REQ-038 SHALL, without CRC_CTRL_POLY_EN, have no ctrl_poly port and use the parameter POLY.

Verification
REQ-039 SHALL cover generate: CRC_W=4, poly 0011, INIT 0, msg_len 8, data 10100110 -> crc_out_bit 1,1,1,0 over 4 cycles, crc_seq=1110, done pulse.
REQ-040 SHALL cover check pass: mode 1, 10100110 then 1110 -> crc_error=0, crc_seq=0000.
REQ-041 SHALL cover check fail: mode 1, 10100010 then 1110 -> crc_error=1.
REQ-042 SHALL cover stalls: data_valid toggled 1/0 during REQ-039 -> identical result, with data_ready high throughout SHIFT.
REQ-043 SHALL cover abort and reset: abort at bit 4, then rst mid-APPEND -> IDLE, no done, crc_seq unchanged, then all outputs 0.
REQ-044 SHALL cover boundary and macro: msg_len=0 -> immediate APPEND emitting INIT; with CRC_CTRL_POLY_EN and ctrl_poly=0011 -> same result as REQ-039.
